// File: rtl/cpu_top.sv
// cpu_top: FPGA-level top of a 16-bit accumulator CPU with a step-enable divider,
// a synchronous single-port program/data RAM and LED / 7-segment / monitor outputs.
module cpu_top #(
    parameter int unsigned DIVISOR    = 50_000_000,
    parameter              FILE_NAME  = "mem_init.mif",
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  kbd,
    input  logic [2:0]  btn,
    input  logic [9:0]  sw,
    output logic [13:0] mnt,
    output logic [9:0]  led,
    output logic [27:0] ssd
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [4:0] {
        FETCH_A = 5'd0,
        FETCH_W = 5'd1,
        FETCH_L = 5'd2,
        DECODE  = 5'd3,
        OPER_W  = 5'd4,
        OPER_L  = 5'd5,
        EXEC    = 5'd6,
        HALTED  = 5'd7
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        div_cnt;
    logic                    tick, step, we, halted, halted_next;
    logic [ADDR_WIDTH-1:0]   pc, pc_next, mar_out, mar_next, addr, a;
    logic [DATA_WIDTH-1:0]   mdr_out, mdr_next, ir_out, ir_next;
    logic [DATA_WIDTH-1:0]   acc, acc_next, out, out_next, data;
    logic [3:0]              opcode;
    logic [2:0]              alu_op_code, alu_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // FILE_NAME only drives the FPGA flow's RAM preload; folded here to keep it referenced
    logic unused_ok;
    assign unused_ok = ^{kbd, btn[2:1], ir_out[DATA_WIDTH-5:ADDR_WIDTH], FILE_NAME};

    assign opcode = ir_out[DATA_WIDTH-1 -: 4];
    assign a      = ir_out[ADDR_WIDTH-1:0];
    assign addr   = mar_out;
    assign tick   = (div_cnt == CNT_W'(DIVISOR - 1));
    assign step   = tick & ~btn[0];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + CNT_W'(1);
    end

    // Synchronous RAM: read data lags the address by one clk
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= acc;
        data <= mem[addr];
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc;
        mar_next    = mar_out;
        mdr_next    = mdr_out;
        ir_next     = ir_out;
        acc_next    = acc;
        out_next    = out;
        alu_next    = alu_op_code;
        halted_next = halted;
        we          = 1'b0;
        case (state_reg)
            FETCH_A: begin
                mar_next   = pc;
                state_next = FETCH_W;
            end
            FETCH_W: state_next = FETCH_L;
            FETCH_L: begin
                mdr_next   = data;
                ir_next    = data;
                pc_next    = pc + ADDR_WIDTH'(1);
                state_next = DECODE;
            end
            DECODE: begin
                mar_next = a;
                alu_next = (opcode inside {[OP_ADD:OP_NOT]}) ? opcode[2:0] : 3'd0;
                if (opcode inside {OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR}) state_next = OPER_W;
                else                                                       state_next = EXEC;
            end
            OPER_W: state_next = OPER_L;
            OPER_L: begin
                mdr_next   = data;
                state_next = EXEC;
            end
            EXEC: begin
                state_next = FETCH_A;
                case (opcode)
                    OP_LD:   acc_next = mdr_out;
                    OP_ST:   we = step;
                    OP_ADD:  acc_next = acc + mdr_out;
                    OP_SUB:  acc_next = acc - mdr_out;
                    OP_AND:  acc_next = acc & mdr_out;
                    OP_OR:   acc_next = acc | mdr_out;
                    OP_NOT:  acc_next = ~acc;
                    OP_IN:   acc_next = DATA_WIDTH'(sw);
                    OP_OUT:  out_next = acc;
                    OP_JMP:  pc_next = a;
                    OP_JZ:   if (acc == '0) pc_next = a;
                    OP_HALT: begin
                        halted_next = 1'b1;
                        state_next  = HALTED;
                    end
                    default: ;
                endcase
            end
            HALTED:  state_next = HALTED;
            default: state_next = FETCH_A;
        endcase
    end

    // CPU registers advance only on enabled, unpaused steps
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg   <= FETCH_A;
            pc          <= '0;
            mar_out     <= '0;
            mdr_out     <= '0;
            ir_out      <= '0;
            acc         <= '0;
            out         <= '0;
            alu_op_code <= '0;
            halted      <= 1'b0;
        end else if (step) begin
            state_reg   <= state_next;
            pc          <= pc_next;
            mar_out     <= mar_next;
            mdr_out     <= mdr_next;
            ir_out      <= ir_next;
            acc         <= acc_next;
            out         <= out_next;
            alu_op_code <= alu_next;
            halted      <= halted_next;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign led = out[9:0];
    assign ssd = {seg7(out[15:12]), seg7(out[11:8]), seg7(out[7:4]), seg7(out[3:0])};
    assign mnt = {6'(pc), opcode, halted, alu_op_code};

endmodule

// File: tb/tb_cpu_top.sv
// tb_cpu_top: scoreboard bench for cpu_top; an instruction-level model predicts
// every retired instruction, the final output/monitor state and the RAM image.
module tb_cpu_top;

    localparam int unsigned DEPTH = 64;
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst, rst4;
    logic [1:0]  kbd = 2'b00;
    logic [2:0]  btn = 3'b000, btn4 = 3'b000;
    logic [9:0]  sw = '0, sw4 = '0;
    logic [13:0] mnt, mnt4;
    logic [9:0]  led, led4;
    logic [27:0] ssd, ssd4;

    always #5 clk = ~clk;

    cpu_top #(.DIVISOR(1)) dut (
        .clk(clk), .rst_n(rst), .kbd(kbd), .btn(btn), .sw(sw),
        .mnt(mnt), .led(led), .ssd(ssd)
    );

    cpu_top #(.DIVISOR(4)) dut4 (
        .clk(clk), .rst_n(rst4), .kbd(kbd), .btn(btn4), .sw(sw4),
        .mnt(mnt4), .led(led4), .ssd(ssd4)
    );

    typedef struct {
        logic [5:0]  pc;
        logic [15:0] acc;
        logic [15:0] out;
    } retire_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    retire_t     exp_q[$];
    retire_t     mon_e;
    logic [15:0] img     [DEPTH];
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] ref_out;
    logic [5:0]  ref_pc;
    logic [4:0]  prev_state = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] ssd_of(input logic [15:0] v);
        return {SEG[v[15:12]], SEG[v[11:8]], SEG[v[7:4]], SEG[v[3:0]]};
    endfunction

    // Instruction-level reference: one loop iteration per instruction
    task automatic run_model(input logic [9:0] swv);
        logic [5:0]  p   = '0;
        logic [15:0] ac  = '0;
        logic [15:0] o   = '0;
        logic [15:0] ins;
        logic [3:0]  op;
        logic [5:0]  a;
        retire_t     r;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = img[k];
        for (int n = 0; n < 500; n++) begin
            ins = ref_mem[p];
            p   = p + 6'd1;
            op  = ins[15:12];
            a   = ins[5:0];
            case (op)
                4'h0: ac = ref_mem[a];
                4'h1: ref_mem[a] = ac;
                4'h2: ac = ac + ref_mem[a];
                4'h3: ac = ac - ref_mem[a];
                4'h4: ac = ac & ref_mem[a];
                4'h5: ac = ac | ref_mem[a];
                4'h6: ac = ~ac;
                4'h7: ac = {6'b0, swv};
                4'h8: o = ac;
                4'h9: p = a;
                4'hA: if (ac == 16'h0) p = a;
                default: ;
            endcase
            r.pc = p; r.acc = ac; r.out = o;
            exp_q.push_back(r);
            if (op == 4'hF) break;
        end
        ref_out = o;
        ref_pc  = p;
    endtask

    // Monitor: an instruction retires when the CPU leaves EXEC
    always @(negedge clk) begin
        if (!rst && prev_state == 5'd6 && dut.state_reg != 5'd6) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL retire_extra: unexpected retire, pc=%0h expected none", dut.pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("retire_pc",  32'(dut.pc),  32'(mon_e.pc));
                check("retire_acc", 32'(dut.acc), 32'(mon_e.acc));
                check("retire_out", 32'(dut.out), 32'(mon_e.out));
            end
        end
        prev_state <= dut.state_reg;
    end

    task automatic clear_img();
        for (int k = 0; k < DEPTH; k++) img[k] = 16'h0000;
    endtask

    task automatic gen_random();
        logic [3:0] op;
        logic [5:0] a;
        for (int k = 0; k < DEPTH; k++) img[k] = 16'($urandom);
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 14));
            if (op == 4'h9 || op == 4'hA) a = 6'($urandom_range(i + 1, 24));
            else if (op == 4'h1)          a = 6'($urandom_range(32, 63));
            else                          a = 6'($urandom_range(0, 63));
            img[i] = {op, 6'($urandom), a};
        end
        for (int i = 24; i < 32; i++) img[i] = 16'hF000;
    endtask

    // Load image, run to HALT (optionally resetting during the abort_at-th EXEC), check end state
    task automatic run_prog(input string name, input logic [9:0] swv, input int abort_at);
        int c;
        int execs;
        rst = 1'b1;
        sw  = swv;
        @(negedge clk);
        for (int k = 0; k < DEPTH; k++) dut.mem[k] <= img[k];
        @(negedge clk);
        exp_q.delete();
        run_model(swv);
        rst = 1'b0;
        if (abort_at > 0) begin
            c = 0;
            execs = 0;
            while (execs < abort_at && c < 2000) begin
                @(negedge clk);
                c++;
                if (dut.state_reg == 5'd6) execs++;
            end
            check({name, "_reach_exec"}, 32'(execs), 32'(abort_at));
            #2 rst = 1'b1;
            #1;
            check({name, "_arst_pc"},    32'(dut.pc),        32'h0);
            check({name, "_arst_state"}, 32'(dut.state_reg), 32'h0);
            check({name, "_arst_out"},   32'(dut.out),       32'h0);
            check({name, "_arst_led"},   32'(led),           32'h0);
            @(negedge clk);
            @(negedge clk);
            check({name, "_st_not_committed"}, 32'(dut.mem[18]), 32'(img[18]));
            exp_q.delete();
            run_model(swv);
            rst = 1'b0;
        end
        c = 0;
        while (dut.state_reg != 5'd7 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({name, "_halted"}, 32'(dut.state_reg), 32'h7);
        repeat (3) @(negedge clk);
        check({name, "_still_halted"}, 32'(dut.state_reg), 32'h7);
        check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
        check({name, "_out"}, 32'(dut.out), 32'(ref_out));
        check({name, "_led"}, 32'(led), 32'(ref_out[9:0]));
        check({name, "_ssd"}, 32'(ssd), 32'(ssd_of(ref_out)));
        check({name, "_mnt"}, 32'(mnt), 32'({ref_pc, 4'hF, 1'b1, 3'b000}));
        for (int k = 0; k < DEPTH; k++) check({name, "_mem"}, 32'(dut.mem[k]), 32'(ref_mem[k]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc_last;
        logic [4:0] s_prev;
        int c;

        rst = 1'b0; rst4 = 1'b0;
        #2;
        rst = 1'b1; rst4 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_pc",    32'(dut.pc),          32'h0);
        check("reset_state", 32'(dut.state_reg),   32'h0);
        check("reset_acc",   32'(dut.acc),         32'h0);
        check("reset_ir",    32'(dut.ir_out),      32'h0);
        check("reset_alu",   32'(dut.alu_op_code), 32'h0);
        check("reset_led",   32'(led),             32'h0);
        check("reset_ssd",   32'(ssd),             32'({4{7'b1000000}}));
        check("reset_mnt",   32'(mnt),             32'h0);

        clear_img();
        img[0] = 16'h7005; img[1] = 16'h8000; img[2] = 16'hF000;
        run_prog("prog_in_out", 10'h155, 0);
        check("prog_in_out_value", 32'(dut.out), 32'h0155);
        check("prog_in_out_ssd",   32'(ssd),     32'({7'h40, 7'h79, 7'h12, 7'h12}));

        clear_img();
        img[0] = 16'h0010; img[1] = 16'h2011; img[2] = 16'h1012; img[3] = 16'h8000;
        img[4] = 16'hF000; img[16] = 16'hFFFF; img[17] = 16'h0002;
        run_prog("prog_wrap_add", 10'h000, 0);
        check("prog_wrap_add_value", 32'(dut.out),     32'h0001);
        check("prog_wrap_add_mem18", 32'(dut.mem[18]), 32'h0001);

        clear_img();
        img[0] = 16'h0010; img[1] = 16'hA003; img[2] = 16'hF000; img[3] = 16'h8000;
        img[4] = 16'hF000; img[16] = 16'h0000;
        run_prog("prog_jz", 10'h3FF, 0);
        check("prog_jz_pc", 32'(dut.pc), 32'h5);

        clear_img();
        img[0] = 16'h0010; img[1] = 16'h8000; img[2] = 16'hF000; img[16] = 16'h89AF;
        run_prog("prog_ssd", 10'h000, 0);
        check("prog_ssd_digits", 32'(ssd), 32'({7'b0000000, 7'b0010000, 7'b0001000, 7'b0001110}));

        clear_img();
        img[0] = 16'h0010; img[1] = 16'h2011; img[2] = 16'h1012; img[3] = 16'h8000;
        img[4] = 16'hF000; img[16] = 16'hFFFF; img[17] = 16'h0002;
        run_prog("prog_reset_mid", 10'h000, 3);

        for (int t = 0; t < 6; t++) begin
            gen_random();
            run_prog("prog_random", 10'($urandom), 0);
        end

        // Divided clock and pause on the DIVISOR=4 instance
        clear_img();
        img[0] = 16'h7005; img[1] = 16'h8000; img[2] = 16'hF000;
        sw4 = 10'h155;
        @(negedge clk);
        for (int k = 0; k < DEPTH; k++) dut4.mem[k] <= img[k];
        @(negedge clk);
        rst4 = 1'b0;
        cyc_last = 0;
        s_prev = dut4.state_reg;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            if (dut4.state_reg != s_prev) begin
                check("div4_period", 32'(cyc - cyc_last), 32'd4);
                cyc_last = cyc;
                s_prev = dut4.state_reg;
            end
        end
        check("div4_pre_pause_state", 32'(dut4.state_reg), 32'h1);
        check("div4_pre_pause_pc",    32'(dut4.pc),        32'h1);
        btn4 = 3'b001;
        repeat (20) @(negedge clk);
        check("pause_state", 32'(dut4.state_reg), 32'h1);
        check("pause_pc",    32'(dut4.pc),        32'h1);
        btn4 = 3'b000;
        c = 0;
        while (dut4.state_reg != 5'd7 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check("div4_halted", 32'(dut4.state_reg), 32'h7);
        check("div4_out",    32'(dut4.out),       32'h0155);
        check("div4_led",    32'(led4),           32'h155);
        check("div4_mnt_halt", 32'(mnt4[3]),      32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
